// File: rtl/mul8_heap_issuer_if.sv
// ---------------------------------------------------------------------------
// mul8_heap_issuer_if
//   Operand and product handshake bundle for mul8_heap_issuer.
//
//   Handshake rule (both directions): a transfer happens on a rising clk edge
//   where valid and ready are both high. The producer holds valid and its
//   payload unchanged until that edge. ready may be asserted independently of
//   valid.
//
//   Signals
//     in_valid / in_ready   operand pair handshake (source -> issuer)
//     in_a, in_b            unsigned 8-bit operands
//     out_valid / out_ready product handshake (issuer -> consumer)
//     out_p                 captured 16-bit product
//     out_err               captured product differs from the reference
//
//   Modports
//     master : operand source / product consumer side
//     slave  : the issuer itself
// ---------------------------------------------------------------------------
interface mul8_heap_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_err
  );
endinterface

// File: rtl/mul8_heap_issuer.sv
// ---------------------------------------------------------------------------
// mul8_heap_issuer
//   Front/back end for an external 8x8 unsigned multiplier bit-heap
//   compressor. Accepts one operand pair, drives the 15 registered
//   partial-product columns, waits LAT cycles, captures the 16 single-bit
//   column results as a product and compares it with a reference product.
//   One transaction in flight at a time.
//
//   Parameters
//     LAT        compressor latency in cycles (0 = combinational), 0..15
//
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     bus              operand/product handshake (slave modport)
//     src0..src14      partial-product column K, srcK[j] = a[lo+j] & b[K-lo-j]
//                      with lo = max(0, K-7)
//     dst0..dst15      compressor result bits, dstK = product bit K
//     err_cnt          saturating count of mismatching transactions
//     busy             state is not IDLE
//     dbg_state        current FSM state (IDLE=0, WAIT=1, HOLD=2)
// ---------------------------------------------------------------------------
module mul8_heap_issuer #(
  parameter int LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  mul8_heap_issuer_if.slave bus,
  output logic [0:0]        src0,
  output logic [1:0]        src1,
  output logic [2:0]        src2,
  output logic [3:0]        src3,
  output logic [4:0]        src4,
  output logic [5:0]        src5,
  output logic [6:0]        src6,
  output logic [7:0]        src7,
  output logic [6:0]        src8,
  output logic [5:0]        src9,
  output logic [4:0]        src10,
  output logic [3:0]        src11,
  output logic [2:0]        src12,
  output logic [1:0]        src13,
  output logic [0:0]        src14,
  input  logic              dst0,  dst1,  dst2,  dst3,
  input  logic              dst4,  dst5,  dst6,  dst7,
  input  logic              dst8,  dst9,  dst10, dst11,
  input  logic              dst12, dst13, dst14, dst15,
  output logic [7:0]        err_cnt,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, capture;
  logic [63:0] src_q, src_d;     // all 15 columns packed, column 0 at bit 0
  logic [15:0] ref_q;
  logic [15:0] out_p_q;
  logic        out_err_q;
  logic [7:0]  err_cnt_q;
  logic [15:0] dst_vec;

  assign dst_vec = {dst15, dst14, dst13, dst12, dst11, dst10, dst9, dst8,
                    dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1, dst0};

  // Column bits are built straight from the incoming operands and registered
  // at accept, so the columns are the registered form of ra/rb and stay put
  // until the next accept.
  always_comb begin
    int idx;
    int lo;
    int w;
    src_d = '0;
    idx   = 0;
    for (int k = 0; k < 15; k++) begin
      lo = (k > 7) ? k - 7 : 0;
      w  = (k < 8) ? k + 1 : 15 - k;
      for (int j = 0; j < 8; j++) begin
        if (j < w) begin
          src_d[idx[5:0]] = bus.in_a[3'(lo + j)] & bus.in_b[3'(k - lo - j)];
          idx = idx + 1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      src_q     <= '0;
      ref_q     <= '0;
      out_p_q   <= '0;
      out_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        src_q <= src_d;
        ref_q <= 16'(bus.in_a) * 16'(bus.in_b);
      end
      if (capture) begin
        out_p_q   <= dst_vec;
        out_err_q <= (dst_vec != ref_q);
        if ((dst_vec != ref_q) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_p     = out_p_q;
  assign bus.out_err   = out_err_q;
  assign busy          = (state_q != IDLE);
  assign err_cnt       = err_cnt_q;
  assign dbg_state     = state_q;

  assign src0  = src_q[0:0];
  assign src1  = src_q[2:1];
  assign src2  = src_q[5:3];
  assign src3  = src_q[9:6];
  assign src4  = src_q[14:10];
  assign src5  = src_q[20:15];
  assign src6  = src_q[27:21];
  assign src7  = src_q[35:28];
  assign src8  = src_q[42:36];
  assign src9  = src_q[48:43];
  assign src10 = src_q[53:49];
  assign src11 = src_q[57:54];
  assign src12 = src_q[60:58];
  assign src13 = src_q[62:61];
  assign src14 = src_q[63:63];

endmodule
